vending_machine_param: RTL
==========================

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL have parameter NPROD, default 3: number of products.
REQ-002 SHALL have parameter AMT_W, default 7: credit width in cents.
REQ-003 SHALL have parameter PRICES, default {7'd65,7'd50,7'd25}: packed NPROD×AMT_W; product i price at bits [i*AMT_W +: AMT_W]; every price a nonzero multiple of 5.
REQ-004 SHALL have parameter STOCK_W, default 4: per-product stock counter width.
REQ-005 SHALL have parameter STOCK_INIT, default 10: stock loaded at reset.
REQ-006 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port R  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports N, D, Q, I  in  1 each  coin levels: nickel 5, dime 10, quarter 25, dollar 100.
REQ-009 SHALL have port sel  in  NPROD  product select levels.
REQ-010 SHALL have port cancel  in  1  refund request level.
REQ-011 SHALL have port vend  out  NPROD  one-hot dispense pulse.
REQ-012 SHALL have port Total_Amount  out  AMT_W  current credit / remaining change.
REQ-013 SHALL have ports chg_q, chg_d, chg_n  out  1 each  change-coin pulses.
REQ-014 SHALL have port coin_rej  out  1  coin rejected pulse.
REQ-015 SHALL have port sold_out  out  1  selected product empty pulse.

Function
REQ-016 SHALL detect coins, sel and cancel on 0->1 transitions sampled at clk; a level held N cycles counts once.
REQ-017 SHALL implement FSM IDLE, VEND, CHANGE; only IDLE accepts coins, selections, cancel.
REQ-018 SHALL, in IDLE, add a detected coin to credit; Total_Amount shows the new value the cycle after the edge is sampled.
REQ-019 SHALL, when several coin edges occur in one cycle, accept only the highest-value coin and pulse coin_rej for the others.
REQ-020 SHALL reject a coin whose addition exceeds 2^AMT_W-1: credit unchanged, coin_rej high one cycle.
REQ-021 SHALL reject every coin edge outside IDLE with a coin_rej pulse; credit unaffected.
REQ-022 SHALL, on simultaneous sel edges, act on the lowest index only.
REQ-023 SHALL ignore a selection with credit < price; no output pulse.
REQ-024 SHALL, on a selection with stock 0 and credit ≥ price, pulse sold_out one cycle, credit kept, stay IDLE.
REQ-025 SHALL, on a valid selection (credit ≥ price, stock > 0), enter VEND next cycle: vend[i]=1 for exactly one cycle, Total_Amount=credit-price, stock[i] decremented.
REQ-026 SHALL, from VEND, go to CHANGE if remainder > 0, else IDLE.
REQ-027 SHALL, in CHANGE, emit per cycle exactly one pulse of the largest coin ≤ remaining (Q>D>N), reducing Total_Amount by it; at 0 return to IDLE.
REQ-028 SHALL, on cancel edge in IDLE with credit > 0, enter CHANGE next cycle and refund all credit; with credit 0, cancel is ignored.
REQ-029 SHALL give selection priority over cancel when both occur in one cycle; a coin edge in that cycle is rejected.
REQ-030 SHALL never underflow stock, and never pulse more than one of vend/chg_*/sold_out per cycle.

Reset
REQ-031 SHALL, with R=0 at a clk edge, force IDLE, credit 0, all stock=STOCK_INIT, all outputs 0, edge-detect history 0, including mid-VEND/CHANGE: no further change pulses after reset.

Verification
REQ-032 SHALL verify reset: R=0 two cycles -> all outputs 0, Total_Amount 0, state IDLE.
REQ-033 SHALL verify N then Q, select sel[0] -> Total 5, 30, vend[0] pulse with Total 5, one chg_n, Total 0.
REQ-034 SHALL verify I, select sel[2] (65) -> vend[2], Total 35, chg_q then chg_d, Total 0.
REQ-035 SHALL verify I,Q -> Total 125, then N -> coin_rej, Total 125; cancel -> 5×chg_q, Total 0.
REQ-036 SHALL verify Q held 3 cycles -> credit 25 once; Q+D same cycle -> +25, coin_rej; coin during CHANGE -> coin_rej.
REQ-037 SHALL verify 10 vends of product 0, 11th with credit 25 -> sold_out, Total 25; R=0 mid-CHANGE -> Total 0, no chg pulses.

Source files
------------

// File: rtl/vending_machine_param.sv
// Parameterised vending machine: coin credit, product select, stock, change.
// Ports: clk, R (sync active-low), N/D/Q/I coins, sel, cancel -> vend, Total_Amount,
//   chg_q/chg_d/chg_n change pulses, coin_rej, sold_out.
module vending_machine_param #(
  parameter int NPROD = 3,
  parameter int AMT_W = 7,
  parameter logic [NPROD*AMT_W-1:0] PRICES = {7'd65, 7'd50, 7'd25},
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 10
) (
  input  logic             clk,
  input  logic             R,
  input  logic             N,
  input  logic             D,
  input  logic             Q,
  input  logic             I,
  input  logic [NPROD-1:0] sel,
  input  logic             cancel,
  output logic [NPROD-1:0] vend,
  output logic [AMT_W-1:0] Total_Amount,
  output logic             chg_q,
  output logic             chg_d,
  output logic             chg_n,
  output logic             coin_rej,
  output logic             sold_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [AMT_W-1:0] V_N = AMT_W'(5);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(10);
  localparam logic [AMT_W-1:0] V_Q = AMT_W'(25);

  localparam logic [AMT_W:0] W_N = (AMT_W+1)'(5);
  localparam logic [AMT_W:0] W_D = (AMT_W+1)'(10);
  localparam logic [AMT_W:0] W_Q = (AMT_W+1)'(25);
  localparam logic [AMT_W:0] W_I = (AMT_W+1)'(100);

  state_t state_q, state_d;

  logic [AMT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0] stock_q [NPROD];
  logic [STOCK_W-1:0] stock_d [NPROD];

  logic [3:0] coin_hist_q, coin_hist_d;
  logic [NPROD-1:0] sel_hist_q, sel_hist_d;
  logic cancel_hist_q, cancel_hist_d;

  logic [NPROD-1:0] vend_q, vend_d;
  logic chg_qtr_q, chg_qtr_d;
  logic chg_dim_q, chg_dim_d;
  logic chg_nkl_q, chg_nkl_d;
  logic coin_rej_q, coin_rej_d;
  logic sold_out_q, sold_out_d;

  logic [3:0] coin_edge;
  logic [NPROD-1:0] sel_edge;
  logic [NPROD-1:0] sel_oh;
  logic cancel_edge;
  logic multi_coin;
  logic cmd;
  logic [AMT_W:0] coin_val;
  logic [AMT_W:0] sum;
  logic [AMT_W-1:0] price_sel;
  logic [STOCK_W-1:0] stock_sel;

  always_comb begin
    coin_hist_d   = {I, Q, D, N};
    sel_hist_d    = sel;
    cancel_hist_d = cancel;

    coin_edge   = {I, Q, D, N} & ~coin_hist_q;
    sel_edge    = sel & ~sel_hist_q;
    cancel_edge = cancel & ~cancel_hist_q;

    // isolate lowest-index select edge
    sel_oh = sel_edge & (~sel_edge + NPROD'(1));

    price_sel = '0;
    stock_sel = '0;
    for (int i = 0; i < NPROD; i++) begin
      if (sel_oh[i]) begin
        price_sel = PRICES[i*AMT_W +: AMT_W];
        stock_sel = stock_q[i];
      end
    end

    // highest-value coin wins
    if (coin_edge[3])      coin_val = W_I;
    else if (coin_edge[2]) coin_val = W_Q;
    else if (coin_edge[1]) coin_val = W_D;
    else if (coin_edge[0]) coin_val = W_N;
    else                   coin_val = '0;

    multi_coin = |(coin_edge & (coin_edge - 4'd1));
    sum        = {1'b0, credit_q} + coin_val;
    // a select or cancel edge makes this a command cycle
    cmd        = (|sel_edge) | cancel_edge;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    stock_d    = stock_q;
    vend_d     = '0;
    chg_qtr_d  = 1'b0;
    chg_dim_d  = 1'b0;
    chg_nkl_d  = 1'b0;
    coin_rej_d = 1'b0;
    sold_out_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|sel_edge) begin
          if (credit_q >= price_sel) begin
            if (stock_sel == '0) begin
              sold_out_d = 1'b1;
            end else begin
              vend_d   = sel_oh;
              credit_d = credit_q - price_sel;
              state_d  = S_VEND;
              for (int i = 0; i < NPROD; i++) begin
                if (sel_oh[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
              end
            end
          end
        end else if (cancel_edge && credit_q != '0) begin
          state_d = S_CHANGE;
        end

        if (|coin_edge) begin
          if (cmd) begin
            coin_rej_d = 1'b1;
          end else begin
            if (multi_coin) coin_rej_d = 1'b1;
            if (sum[AMT_W]) coin_rej_d = 1'b1;
            else            credit_d   = sum[AMT_W-1:0];
          end
        end
      end

      S_VEND: begin
        coin_rej_d = |coin_edge;
        state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        coin_rej_d = |coin_edge;
        if (credit_q >= V_Q) begin
          chg_qtr_d = 1'b1;
          credit_d  = credit_q - V_Q;
        end else if (credit_q >= V_D) begin
          chg_dim_d = 1'b1;
          credit_d  = credit_q - V_D;
        end else if (credit_q >= V_N) begin
          chg_nkl_d = 1'b1;
          credit_d  = credit_q - V_N;
        end else begin
          credit_d  = '0;
        end
        if (credit_d == '0) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      for (int i = 0; i < NPROD; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
      coin_hist_q   <= '0;
      sel_hist_q    <= '0;
      cancel_hist_q <= 1'b0;
      vend_q        <= '0;
      chg_qtr_q     <= 1'b0;
      chg_dim_q     <= 1'b0;
      chg_nkl_q     <= 1'b0;
      coin_rej_q    <= 1'b0;
      sold_out_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      coin_hist_q   <= coin_hist_d;
      sel_hist_q    <= sel_hist_d;
      cancel_hist_q <= cancel_hist_d;
      vend_q        <= vend_d;
      chg_qtr_q     <= chg_qtr_d;
      chg_dim_q     <= chg_dim_d;
      chg_nkl_q     <= chg_nkl_d;
      coin_rej_q    <= coin_rej_d;
      sold_out_q    <= sold_out_d;
    end
  end

  assign vend         = vend_q;
  assign Total_Amount = credit_q;
  assign chg_q        = chg_qtr_q;
  assign chg_d        = chg_dim_q;
  assign chg_n        = chg_nkl_q;
  assign coin_rej     = coin_rej_q;
  assign sold_out     = sold_out_q;

endmodule
